// File: rtl/mips_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// mips_fsm_ctrl
//
// Purpose:
//   Multicycle MIPS-lite control unit. A Moore FSM steps each instruction
//   through FETCH -> DECODE -> EXEC -> MEM -> WB, skipping stages the
//   instruction does not need. It also counts retired instructions.
//   Supported instructions are addu, subu, ori, lui, lw, sw, beq, jal and jr.
//   Any other opcode, or any other R-type func, executes as a nop.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   opcode     in   instr[31:26] from IR, stable from DECODE onward
//   func       in   instr[5:0] from IR
//   zero       in   ALU equality flag, used by beq in EXEC
//   PCWr       out  PC write enable
//   IRWr       out  IR write enable
//   RegWr      out  register file write enable
//   MemWr      out  data memory write enable
//   ALUOp      out  000 R-type, 001 add, 010 sub, 011 or, 111 lui
//   NPCOp      out  00 PC+4, 01 branch, 10 jump imm26, 11 jump register
//   RegDst     out  00 rt, 01 rd, 10 $31
//   WDSel      out  00 ALU, 01 DM, 10 PC+4
//   ALUSrc     out  1 selects the extended immediate
//   ExtOp      out  1 sign-extend, 0 zero-extend
//   state      out  current state code, for debug
//   instr_cnt  out  number of retired instructions, wraps at 2^32
// ---------------------------------------------------------------------------
module mips_fsm_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic [2:0]  ALUOp,
  output logic [1:0]  NPCOp,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic        ALUSrc,
  output logic        ExtOp,
  output logic [2:0]  state,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU,
    I_SUBU,
    I_ORI,
    I_LUI,
    I_LW,
    I_SW,
    I_BEQ,
    I_JAL,
    I_JR,
    I_NOP
  } instr_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b111;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_J26    = 2'b10;
  localparam logic [1:0] NPC_JREG   = 2'b11;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_RA  = 2'b10;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DM   = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;

  state_t      cur_state;
  state_t      nxt_state;
  instr_t      iclass;
  logic        retire;
  logic [2:0]  exec_alu_op;
  logic [31:0] cnt;

  logic        pc_wr_raw;
  logic        ir_wr_raw;
  logic        reg_wr_raw;
  logic        mem_wr_raw;

  // Classify the instruction held in IR. Opcode and func are stable from
  // DECODE until the instruction retires, so decoding them directly every
  // cycle is equivalent to latching the class once.
  always_comb begin
    iclass = I_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: iclass = I_ADDU;
          FN_SUBU: iclass = I_SUBU;
          FN_JR:   iclass = I_JR;
          default: iclass = I_NOP;
        endcase
      end
      OP_JAL:  iclass = I_JAL;
      OP_BEQ:  iclass = I_BEQ;
      OP_ORI:  iclass = I_ORI;
      OP_LUI:  iclass = I_LUI;
      OP_LW:   iclass = I_LW;
      OP_SW:   iclass = I_SW;
      default: iclass = I_NOP;
    endcase
  end

  // ALU operation of the instruction. It is presented from EXEC until the
  // instruction leaves MEM/WB so the ALU result register is not disturbed.
  always_comb begin
    exec_alu_op = ALU_ADD;
    case (iclass)
      I_ADDU, I_SUBU: exec_alu_op = ALU_RTYPE;
      I_ORI:          exec_alu_op = ALU_OR;
      I_LUI:          exec_alu_op = ALU_LUI;
      I_LW, I_SW:     exec_alu_op = ALU_ADD;
      I_BEQ:          exec_alu_op = ALU_SUB;
      default:        exec_alu_op = ALU_ADD;
    endcase
  end

  // Next-state routing. Jumps and nops finish in DECODE, beq in EXEC,
  // sw in MEM, everything else writes back in WB. retire marks the cycle
  // whose closing edge completes an instruction.
  always_comb begin
    nxt_state = S_FETCH;
    retire    = 1'b0;
    case (cur_state)
      S_FETCH: begin
        nxt_state = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ: nxt_state = S_EXEC;
          default: begin
            nxt_state = S_FETCH;
            retire    = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        case (iclass)
          I_BEQ: begin
            nxt_state = S_FETCH;
            retire    = 1'b1;
          end
          I_LW, I_SW: nxt_state = S_MEM;
          default:    nxt_state = S_WB;
        endcase
      end
      S_MEM: begin
        if (iclass == I_SW) begin
          nxt_state = S_FETCH;
          retire    = 1'b1;
        end else begin
          nxt_state = S_WB;
        end
      end
      S_WB: begin
        nxt_state = S_FETCH;
        retire    = 1'b1;
      end
      default: begin
        nxt_state = S_FETCH;
      end
    endcase
  end

  // State register and retired-instruction counter. Reset abandons any
  // instruction in flight without counting it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
      cnt       <= 32'd0;
    end else begin
      cur_state <= nxt_state;
      if (retire) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // Moore output decode from state and instruction class. beq's PCWr is
  // the one place the zero flag enters, qualifying the branch in EXEC.
  always_comb begin
    pc_wr_raw  = 1'b0;
    ir_wr_raw  = 1'b0;
    reg_wr_raw = 1'b0;
    mem_wr_raw = 1'b0;
    ALUOp      = ALU_ADD;
    NPCOp      = NPC_PC4;
    RegDst     = DST_RT;
    WDSel      = WD_ALU;
    ALUSrc     = 1'b0;
    ExtOp      = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ir_wr_raw = 1'b1;
        pc_wr_raw = 1'b1;
        NPCOp     = NPC_PC4;
      end
      S_DECODE: begin
        if (iclass == I_JAL) begin
          pc_wr_raw  = 1'b1;
          NPCOp      = NPC_J26;
          reg_wr_raw = 1'b1;
          RegDst     = DST_RA;
          WDSel      = WD_PC4;
        end else if (iclass == I_JR) begin
          pc_wr_raw  = 1'b1;
          NPCOp      = NPC_JREG;
        end
      end
      S_EXEC: begin
        ALUOp = exec_alu_op;
        case (iclass)
          I_LW, I_SW: begin
            ALUSrc = 1'b1;
            ExtOp  = 1'b1;
          end
          I_ORI, I_LUI: begin
            ALUSrc = 1'b1;
            ExtOp  = 1'b0;
          end
          I_BEQ: begin
            pc_wr_raw = zero;
            NPCOp     = NPC_BRANCH;
          end
          default: begin
          end
        endcase
      end
      S_MEM: begin
        ALUOp      = exec_alu_op;
        mem_wr_raw = (iclass == I_SW);
      end
      S_WB: begin
        ALUOp = exec_alu_op;
        case (iclass)
          I_ADDU, I_SUBU: begin
            reg_wr_raw = 1'b1;
            RegDst     = DST_RD;
            WDSel      = WD_ALU;
          end
          I_ORI, I_LUI: begin
            reg_wr_raw = 1'b1;
            RegDst     = DST_RT;
            WDSel      = WD_ALU;
          end
          I_LW: begin
            reg_wr_raw = 1'b1;
            RegDst     = DST_RT;
            WDSel      = WD_DM;
          end
          default: begin
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  // The state register sits at FETCH during reset, whose decode would
  // otherwise assert PCWr/IRWr; gating keeps all write enables low for
  // the whole time reset is high, independent of the clock.
  assign PCWr  = pc_wr_raw  & ~reset;
  assign IRWr  = ir_wr_raw  & ~reset;
  assign RegWr = reg_wr_raw & ~reset;
  assign MemWr = mem_wr_raw & ~reset;

  assign state     = cur_state;
  assign instr_cnt = cnt;

endmodule

// File: tb/tb_mips_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_fsm_ctrl
//
// Purpose:
//   Self-checking bench for mips_fsm_ctrl. Each instruction is described by
//   its mnemonic; a reference model derives the expected cycle-by-cycle
//   control word from that mnemonic, and the retired count is tracked as a
//   plain integer. Directed cases come first, followed by a random program
//   and a reset injected in the MEM stage of a lw.
// ---------------------------------------------------------------------------
module tb_mips_fsm_ctrl;

  typedef enum int {
    K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR,
    K_BADOP, K_BADFN
  } kind_t;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        zero;
  logic        PCWr;
  logic        IRWr;
  logic        RegWr;
  logic        MemWr;
  logic [2:0]  ALUOp;
  logic [1:0]  NPCOp;
  logic [1:0]  RegDst;
  logic [1:0]  WDSel;
  logic        ALUSrc;
  logic        ExtOp;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  int          checks;
  int          failures;
  logic [31:0] exp_cnt;

  mips_fsm_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .func      (func),
    .zero      (zero),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .RegWr     (RegWr),
    .MemWr     (MemWr),
    .ALUOp     (ALUOp),
    .NPCOp     (NPCOp),
    .RegDst    (RegDst),
    .WDSel     (WDSel),
    .ALUSrc    (ALUSrc),
    .ExtOp     (ExtOp),
    .state     (state),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check, and on mismatch counts the
  // failure and reports tag, observed and expected.
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Total number of cycles an instruction spends, FETCH included.
  function automatic int num_cycles(input kind_t k);
    case (k)
      K_LW:                          return 5;
      K_ADDU, K_SUBU, K_ORI, K_LUI,
      K_SW:                          return 4;
      K_BEQ:                         return 3;
      default:                       return 2;
    endcase
  endfunction

  // Reference control word for cycle idx of instruction k, packed as
  // {state, PCWr, IRWr, RegWr, MemWr, ALUOp, NPCOp, RegDst, WDSel, ALUSrc, ExtOp}.
  function automatic logic [17:0] expect_word(input kind_t k, input int idx,
                                              input logic z);
    logic [2:0] st, alu, op_alu;
    logic       pc, ir, rw, mw, src, ext;
    logic [1:0] npc, rd, wd;
    st = 3'd0; pc = 0; ir = 0; rw = 0; mw = 0; src = 0; ext = 0;
    npc = 2'd0; rd = 2'd0; wd = 2'd0; alu = 3'b001;
    case (k)
      K_ADDU, K_SUBU: op_alu = 3'b000;
      K_ORI:          op_alu = 3'b011;
      K_LUI:          op_alu = 3'b111;
      K_BEQ:          op_alu = 3'b010;
      default:        op_alu = 3'b001;
    endcase
    if (idx == 0) begin
      st = 3'd0; pc = 1; ir = 1;
    end else if (idx == 1) begin
      st = 3'd1;
      if (k == K_JAL) begin pc = 1; npc = 2'b10; rw = 1; rd = 2'b10; wd = 2'b10; end
      if (k == K_JR)  begin pc = 1; npc = 2'b11; end
    end else if (idx == 2) begin
      st = 3'd2; alu = op_alu;
      if (k == K_LW || k == K_SW)   begin src = 1; ext = 1; end
      if (k == K_ORI || k == K_LUI) src = 1;
      if (k == K_BEQ) begin pc = z; npc = 2'b01; end
    end else if (idx == 3) begin
      alu = op_alu;
      if (k == K_LW || k == K_SW) begin
        st = 3'd3; mw = (k == K_SW);
      end else begin
        st = 3'd4; rw = 1; rd = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
      end
    end else begin
      st = 3'd4; rw = 1; wd = 2'b01;
    end
    return {st, pc, ir, rw, mw, alu, npc, rd, wd, src, ext};
  endfunction

  function automatic logic [17:0] observed_word();
    return {state, PCWr, IRWr, RegWr, MemWr, ALUOp, NPCOp, RegDst, WDSel, ALUSrc, ExtOp};
  endfunction

  // Instruction encodings; the two nop kinds get random unused codes.
  task automatic encode(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] r;
    fn = 6'($urandom);
    op = 6'b000000;
    case (k)
      K_ADDU: fn = 6'b100001;
      K_SUBU: fn = 6'b100011;
      K_JR:   fn = 6'b001000;
      K_ORI:  op = 6'b001101;
      K_LUI:  op = 6'b001111;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_JAL:  op = 6'b000011;
      K_BADOP: begin
        r = 6'($urandom);
        while (r inside {6'd0, 6'd3, 6'd4, 6'd13, 6'd15, 6'd35, 6'd43}) r = 6'($urandom);
        op = r;
      end
      default: begin
        r = 6'($urandom);
        while (r inside {6'b100001, 6'b100011, 6'b001000}) r = 6'($urandom);
        fn = r;
      end
    endcase
  endtask

  // Runs up to max_cycles cycles of instruction k with a fixed zero flag,
  // checking the control word and retired count in every cycle. A fully
  // executed instruction bumps the model's retired count.
  task automatic apply_stimulus(input kind_t k, input logic z, input int max_cycles,
                                input logic [5:0] op, input logic [5:0] fn);
    int n;
    n = num_cycles(k);
    if (max_cycles < n) n = max_cycles;
    for (int idx = 0; idx < n; idx++) begin
      @(negedge clk);
      opcode = op;
      func   = fn;
      zero   = z;
      #1;
      check_output($sformatf("%s_c%0d_ctrl", k.name(), idx),
                   {14'd0, observed_word()}, {14'd0, expect_word(k, idx, z)});
      check_output($sformatf("%s_c%0d_cnt", k.name(), idx), instr_cnt, exp_cnt);
    end
    if (n == num_cycles(k)) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic run_instr(input kind_t k, input logic z);
    logic [5:0] op, fn;
    encode(k, op, fn);
    apply_stimulus(k, z, 8, op, fn);
  endtask

  task automatic check_reset_view(input string tag);
    check_output({tag, "_state"}, {29'd0, state}, 32'd0);
    check_output({tag, "_enables"}, {28'd0, PCWr, IRWr, RegWr, MemWr}, 32'd0);
    check_output({tag, "_cnt"}, instr_cnt, 32'd0);
  endtask

  initial begin
    kind_t      k;
    logic [5:0] op, fn;
    checks   = 0;
    failures = 0;
    exp_cnt  = 32'd0;
    reset    = 1'b1;
    opcode   = 6'b000000;
    func     = 6'b100001;
    zero     = 1'b0;

    #2;
    check_reset_view("reset_t0");
    repeat (2) @(posedge clk);
    #1;
    check_reset_view("reset_held");
    reset = 1'b0;

    // Directed program: every instruction class and both beq outcomes.
    run_instr(K_ADDU, 1'b0);
    run_instr(K_LW,   1'b0);
    run_instr(K_SW,   1'b1);
    run_instr(K_BEQ,  1'b1);
    run_instr(K_BEQ,  1'b0);
    run_instr(K_JAL,  1'b0);
    run_instr(K_JR,   1'b0);
    apply_stimulus(K_BADOP, 1'b0, 8, 6'b111111, 6'b000000);
    run_instr(K_BADFN, 1'b1);
    run_instr(K_SUBU, 1'b1);
    run_instr(K_ORI,  1'b0);
    run_instr(K_LUI,  1'b1);

    // Random program.
    for (int i = 0; i < 80; i++) begin
      k = kind_t'($urandom_range(0, 10));
      run_instr(k, 1'($urandom));
    end

    // Reset asserted while a lw sits in MEM: abandoned without retiring.
    encode(K_LW, op, fn);
    apply_stimulus(K_LW, 1'b0, 3, op, fn);
    @(negedge clk);
    #1;
    check_output("lw_mem_reached", {29'd0, state}, 32'd3);
    reset = 1'b1;
    #1;
    check_reset_view("reset_mid_lw");
    exp_cnt = 32'd0;
    @(posedge clk);
    #1;
    check_reset_view("reset_mid_lw_edge");
    reset = 1'b0;
    run_instr(K_ADDU, 1'b0);
    run_instr(K_SW, 1'b0);

    @(negedge clk);
    #1;
    check_output("final_fetch_state", {29'd0, state}, 32'd0);
    check_output("final_cnt", instr_cnt, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
